spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles between consecutive transfers (0..15).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning max cycles in WAIT before abort (1..255).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-requester transfer request, level, held until ack.
REQ-006 SHALL have port req_data  input  64  requester i word at bits [16i+15:16i].
REQ-007 SHALL have port gnt  output  4  one-hot grant, held from arbitration until completion.
REQ-008 SHALL have port ack  output  4  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port err  output  1  one-cycle pulse on timeout abort.
REQ-010 SHALL have port cs_sel_l  output  4  active-low per-slave chip select, one-cold or all-high.
REQ-011 SHALL have port m_start  output  1  one-cycle start pulse to the SPI master.
REQ-012 SHALL have port m_data  output  16  word for the SPI master, stable from grant to completion.
REQ-013 SHALL have port m_busy  input  1  SPI master busy.
REQ-014 SHALL have port m_done  input  1  SPI master one-cycle done pulse.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT, GAP; all outputs registered.
REQ-017 IDLE, req!=0 at edge E0: SHALL select the winner round-robin, searching from last_grant+1 mod 4 upward and wrapping, then set gnt, drive cs_sel_l[winner]=0, load m_data from the winner slice and go to START.
REQ-018 IDLE, req==0: SHALL remain in IDLE with gnt=0 and cs_sel_l=4'hF.
REQ-019 START: SHALL hold while m_busy=1; at the first edge with m_busy=0, SHALL assert m_start for exactly one cycle and go to WAIT.
REQ-020 WAIT: SHALL count cycles from 0; on m_done=1 SHALL pulse ack[winner] one cycle, clear gnt, set cs_sel_l=4'hF, set last_grant=winner and go to GAP.
REQ-021 WAIT timeout: if the count reaches TIMEOUT without m_done, SHALL pulse err one cycle and release gnt/cs as in REQ-020 with no ack, update last_grant and go to GAP.
REQ-022 m_done and the timeout in the same cycle: m_done SHALL win, giving ack and no err.
REQ-023 GAP: SHALL load the counter with GAP_CYCLES, decrement per cycle and go to IDLE at 0; if GAP_CYCLES=0, SHALL go directly from WAIT to IDLE.
REQ-024 Fixed latency with m_busy=0: gnt/cs after E0, m_start in cycle E0+1, earliest ack the cycle after m_done is sampled.
REQ-025 req[winner] dropping during START/WAIT SHALL NOT abort the transfer; it SHALL complete and ack normally.
REQ-026 req and req_data changes while busy SHALL be ignored until the next IDLE arbitration.
REQ-027 m_done outside WAIT SHALL be ignored.
REQ-028 At most one gnt bit and at most one cs_sel_l low bit SHALL be active at any time; gnt and cs_sel_l SHALL always agree.
REQ-029 The timeout counter SHALL be 8 bits, SHALL saturate and SHALL NOT wrap.

Reset
REQ-030 Reset SHALL immediately force state=IDLE, gnt=0, ack=0, err=0, m_start=0, cs_sel_l=4'hF, m_data=0, busy=0, last_grant=3, and clear all counters.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no ack; after release, arbitration SHALL restart with requester 0 highest priority.

Verification
REQ-032 Single request: req=4'b0100, slice2=16'hA5C3, m_busy=0 -> gnt=4'b0100 and cs_sel_l=4'b1011 after E0, m_data=16'hA5C3, m_start pulse at E0+1; on m_done, ack=4'b0100 for one cycle, then cs_sel_l=4'hF.
REQ-033 Fairness: req=4'b1111 held and answered by m_done each time -> grant order 0,1,2,3,0, with GAP_CYCLES idle cycles between ack and the next gnt.
REQ-034 Busy master: m_busy=1 for 5 cycles after grant -> m_start asserted only on the first cycle after m_busy falls, exactly once.
REQ-035 Timeout: TIMEOUT=8, no m_done -> err pulse 8 cycles into WAIT, no ack, cs released, next requester served.
REQ-036 Reset mid-WAIT: reset pulse during WAIT -> all outputs at reset values immediately; with req=4'b1001 afterward, requester 0 is granted first.

Source files
------------

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester + SPI master bundle for spi_arbiter.
// slave = arbiter side, master = requesters / SPI master side.
interface spi_arbiter_if;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        err;
  logic [3:0]  cs_sel_l;
  logic        m_start;
  logic [15:0] m_data;
  logic        m_busy;
  logic        m_done;
  logic        busy;

  modport slave (
    input  req,
    input  req_data,
    input  m_busy,
    input  m_done,
    output gnt,
    output ack,
    output err,
    output cs_sel_l,
    output m_start,
    output m_data,
    output busy
  );

  modport master (
    output req,
    output req_data,
    output m_busy,
    output m_done,
    input  gnt,
    input  ack,
    input  err,
    input  cs_sel_l,
    input  m_start,
    input  m_data,
    input  busy
  );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: 4-way round-robin arbiter in front of one SPI master.
// Ports: clk, reset (async, high), bus (spi_arbiter_if.slave).
module spi_arbiter #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         reset,
  spi_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    GAP
  } state_e;

  // Abort fires on the edge that would complete TIMEOUT WAIT cycles.
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);
  localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES);
  localparam bit         NO_GAP = (GAP_CYCLES == 0);

  state_e      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  ack_q, ack_d;
  logic        err_q, err_d;
  logic [3:0]  cs_q, cs_d;
  logic        m_start_q, m_start_d;
  logic [15:0] m_data_q, m_data_d;
  logic        busy_q, busy_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  win_q, win_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;

  logic [1:0]  pick;
  logic        pick_vld;
  logic [1:0]  cand;

  // Search last+1, last+2, ... wrapping; first requester found wins.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    cand     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ack_d      = 4'h0;
    err_d      = 1'b0;
    cs_d       = cs_q;
    m_start_d  = 1'b0;
    m_data_d   = m_data_q;
    last_d     = last_q;
    win_d      = win_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d  = START;
          win_d    = pick;
          gnt_d    = 4'b0001 << pick;
          cs_d     = ~(4'b0001 << pick);
          m_data_d = bus.req_data[{pick, 4'b0000} +: 16];
        end else begin
          gnt_d = 4'h0;
          cs_d  = 4'hF;
        end
      end

      START: begin
        if (!bus.m_busy) begin
          m_start_d  = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        if (bus.m_done || wait_cnt_q >= TO_LIM) begin
          // m_done has priority over a coincident timeout.
          if (bus.m_done) begin
            ack_d = gnt_q;
          end else begin
            err_d = 1'b1;
          end
          gnt_d     = 4'h0;
          cs_d      = 4'hF;
          last_d    = win_q;
          gap_cnt_d = GAP_LD;
          state_d   = NO_GAP ? IDLE : GAP;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      GAP: begin
        if (gap_cnt_q <= 4'd1) begin
          gap_cnt_d = 4'd0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 4'h0;
      ack_q      <= 4'h0;
      err_q      <= 1'b0;
      cs_q       <= 4'hF;
      m_start_q  <= 1'b0;
      m_data_q   <= 16'h0000;
      busy_q     <= 1'b0;
      last_q     <= 2'd3;
      win_q      <= 2'd0;
      wait_cnt_q <= 8'd0;
      gap_cnt_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      cs_q       <= cs_d;
      m_start_q  <= m_start_d;
      m_data_q   <= m_data_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      win_q      <= win_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.cs_sel_l = cs_q;
  assign bus.m_start  = m_start_q;
  assign bus.m_data   = m_data_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed bench for spi_arbiter.
// Runs with GAP_CYCLES=2, TIMEOUT=8.
module tb_spi_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  spi_arbiter_if bus ();

  spi_arbiter #(
    .GAP_CYCLES(2),
    .TIMEOUT   (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gnt one-hot-or-zero and cs_sel_l its complement, every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if (!$onehot0(bus.gnt) || bus.cs_sel_l !== ~bus.gnt) begin
        n_fail++;
        $display("FAIL gnt_cs_agree: gnt=%b cs_sel_l=%b want one-hot0 gnt and cs=~gnt",
                 bus.gnt, bus.cs_sel_l);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b want 0 within 20 cycles", bus.busy);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.req       = 4'h0;
    bus.req_data  = 64'h0;
    bus.m_busy    = 1'b0;
    bus.m_done    = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.gnt !== 4'h0 || bus.cs_sel_l !== 4'hF || bus.ack !== 4'h0 ||
        bus.err !== 1'b0 || bus.m_start !== 1'b0 || bus.m_data !== 16'h0 ||
        bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: gnt=%b cs=%b ack=%b err=%b st=%b data=%h busy=%b want 0/F/0/0/0/0/0",
               bus.gnt, bus.cs_sel_l, bus.ack, bus.err, bus.m_start,
               bus.m_data, bus.busy);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus.gnt !== 4'h0 || bus.busy !== 1'b0 || bus.cs_sel_l !== 4'hF) begin
      n_fail++;
      $display("FAIL idle_noreq: gnt=%b busy=%b cs=%b want 0 0 F",
               bus.gnt, bus.busy, bus.cs_sel_l);
    end
  endtask

  task automatic test_single();
    bus.req_data = {16'h4444, 16'hA5C3, 16'h2222, 16'h1111};
    bus.req      = 4'b0100;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0100 || bus.cs_sel_l !== 4'b1011 ||
        bus.m_data !== 16'hA5C3 || bus.m_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b cs=%b data=%h st=%b want 0100 1011 a5c3 0",
               bus.gnt, bus.cs_sel_l, bus.m_data, bus.m_start);
    end
    tick();
    n_checks++;
    if (bus.m_start !== 1'b1) begin
      n_fail++;
      $display("FAIL single_start: m_start=%b want 1", bus.m_start);
    end
    bus.req = 4'h0;
    tick();
    n_checks++;
    if (bus.m_start !== 1'b0 || bus.gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_hold: m_start=%b gnt=%b want 0 0100",
               bus.m_start, bus.gnt);
    end
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    n_checks++;
    if (bus.ack !== 4'b0100 || bus.gnt !== 4'h0 ||
        bus.cs_sel_l !== 4'hF || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack: ack=%b gnt=%b cs=%b err=%b want 0100 0 F 0",
               bus.ack, bus.gnt, bus.cs_sel_l, bus.err);
    end
    tick();
    n_checks++;
    if (bus.ack !== 4'h0) begin
      n_fail++;
      $display("FAIL single_ack_pulse: ack=%b want 0", bus.ack);
    end
    wait_idle();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [5];
    int         gap;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    bus.req = 4'hF;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bus.gnt !== exp_g[k]) begin
        n_fail++;
        $display("FAIL fair_gnt[%0d]: gnt=%b want %b", k, bus.gnt, exp_g[k]);
      end
      tick();
      bus.m_done = 1'b1;
      tick();
      bus.m_done = 1'b0;
      n_checks++;
      if (bus.ack !== exp_g[k]) begin
        n_fail++;
        $display("FAIL fair_ack[%0d]: ack=%b want %b", k, bus.ack, exp_g[k]);
      end
      if (k < 4) begin
        gap = 0;
        tick();
        while (bus.gnt === 4'h0 && gap < 20) begin
          gap++;
          tick();
        end
        n_checks++;
        if (gap != 2) begin
          n_fail++;
          $display("FAIL fair_gap[%0d]: idle=%0d want 2", k, gap);
        end
      end
    end
    bus.req = 4'h0;
    wait_idle();
  endtask

  task automatic test_busy_master();
    int starts;
    int first_at;
    starts   = 0;
    first_at = -1;
    bus.req_data = {16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    bus.req      = 4'b0010;
    bus.m_busy   = 1'b1;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0010 || bus.m_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL busy_grant: gnt=%b data=%h want 0010 beef",
               bus.gnt, bus.m_data);
    end
    bus.req_data = {16'h0000, 16'h0000, 16'h1234, 16'h0000};
    bus.m_done   = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 5) bus.m_busy = 1'b0;
      tick();
      bus.m_done = 1'b0;
      if (bus.m_start === 1'b1) begin
        starts++;
        if (first_at < 0) first_at = c;
      end
    end
    n_checks++;
    if (starts != 1 || first_at != 5) begin
      n_fail++;
      $display("FAIL busy_start: starts=%0d at=%0d want 1 at 5", starts, first_at);
    end
    n_checks++;
    if (bus.m_data !== 16'hBEEF || bus.ack !== 4'h0) begin
      n_fail++;
      $display("FAIL busy_stable: data=%h ack=%b want beef 0",
               bus.m_data, bus.ack);
    end
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    n_checks++;
    if (bus.ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL busy_ack: ack=%b want 0010", bus.ack);
    end
    bus.req = 4'h0;
    wait_idle();
  endtask

  task automatic test_timeout();
    int wc;
    int acks;
    wc   = 0;
    acks = 0;
    bus.req = 4'b1100;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL to_grant: gnt=%b want 0100", bus.gnt);
    end
    tick();
    while (bus.err !== 1'b1 && wc < 20) begin
      tick();
      wc++;
      if (bus.ack !== 4'h0) acks++;
    end
    n_checks++;
    if (wc != 8 || acks != 0) begin
      n_fail++;
      $display("FAIL to_err: wait_cycles=%0d acks=%0d want 8 0", wc, acks);
    end
    n_checks++;
    if (bus.gnt !== 4'h0 || bus.cs_sel_l !== 4'hF) begin
      n_fail++;
      $display("FAIL to_release: gnt=%b cs=%b want 0 F", bus.gnt, bus.cs_sel_l);
    end
    tick();
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_err_pulse: err=%b want 0", bus.err);
    end
    wc = 0;
    while (bus.gnt === 4'h0 && wc < 20) begin
      tick();
      wc++;
    end
    n_checks++;
    if (bus.gnt !== 4'b1000 || bus.cs_sel_l !== 4'b0111) begin
      n_fail++;
      $display("FAIL to_next: gnt=%b cs=%b want 1000 0111", bus.gnt, bus.cs_sel_l);
    end
    tick();
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    n_checks++;
    if (bus.ack !== 4'b1000) begin
      n_fail++;
      $display("FAIL to_next_ack: ack=%b want 1000", bus.ack);
    end
    bus.req = 4'h0;
    wait_idle();
  endtask

  task automatic test_done_vs_timeout();
    bus.req = 4'b0001;
    tick();
    tick();
    for (int c = 0; c < 7; c++) tick();
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    n_checks++;
    if (bus.ack !== 4'b0001 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL race_done: ack=%b err=%b want 0001 0", bus.ack, bus.err);
    end
    bus.req = 4'h0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b1001;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_pre_grant: gnt=%b want 1000", bus.gnt);
    end
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.gnt !== 4'h0 || bus.cs_sel_l !== 4'hF || bus.busy !== 1'b0 ||
        bus.m_data !== 16'h0 || bus.ack !== 4'h0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: gnt=%b cs=%b busy=%b data=%h ack=%b err=%b want reset values",
               bus.gnt, bus.cs_sel_l, bus.busy, bus.m_data, bus.ack, bus.err);
    end
    #1 reset = 1'b0;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0001 || bus.cs_sel_l !== 4'b1110) begin
      n_fail++;
      $display("FAIL rst_regrant: gnt=%b cs=%b want 0001 1110",
               bus.gnt, bus.cs_sel_l);
    end
    tick();
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    n_checks++;
    if (bus.ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_ack: ack=%b want 0001", bus.ack);
    end
    bus.req = 4'h0;
    wait_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_fairness();
    test_busy_master();
    test_timeout();
    test_done_vs_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
